// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and result decode for the serial magnitude comparator
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } cmp_state_t;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_GT = 2'd1,
        CMP_LT = 2'd2
    } cmp_res_t;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_flags_t;

    function automatic cmp_flags_t decode_res(input cmp_res_t res);
        cmp_flags_t f;
        f = '0;
        case (res)
            CMP_GT:  f.gt = 1'b1;
            CMP_LT:  f.lt = 1'b1;
            default: f.eq = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/bit_cmp_cell.sv
// rtl/bit_cmp_cell.sv - combinational single-bit magnitude compare cell
module bit_cmp_cell (
    input  logic a,
    input  logic b,
    output logic gt,
    output logic lt,
    output logic eq
);

    assign gt = a & ~b;
    assign lt = ~a & b;
    assign eq = ~(a ^ b);

endmodule

// File: rtl/serial_mag_comparator.sv
// rtl/serial_mag_comparator.sv - MSB-first bit-serial unsigned magnitude comparator
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             a_eq_b,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    cmp_state_t       r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [CNT_W-1:0] r_cnt;
    cmp_res_t         r_res;

    logic       w_gt;
    logic       w_lt;
    logic       w_eq;
    logic       w_first_diff;
    cmp_flags_t w_flags;

    bit_cmp_cell u_cell (
        .a  (r_sa[WIDTH-1]),
        .b  (r_sb[WIDTH-1]),
        .gt (w_gt),
        .lt (w_lt),
        .eq (w_eq)
    );

    // Only the first differing bit decides; res stays EQ until then.
    assign w_first_diff = !w_eq && (r_res == CMP_EQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_cnt   <= '0;
            r_res   <= CMP_EQ;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sa    <= in_a;
                        r_sb    <= in_b;
                        r_cnt   <= CNT_INIT;
                        r_res   <= CMP_EQ;
                        r_state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (w_first_diff) begin
                        r_res <= w_gt ? CMP_GT : CMP_LT;
                    end
                    r_sa  <= r_sa << 1;
                    r_sb  <= r_sb << 1;
                    r_cnt <= r_cnt - CNT_ONE;
                    if ((r_cnt == '0) || (EARLY_EXIT && w_first_diff)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_flags   = decode_res(r_res);
    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == COMPARE);
    assign out_valid = (r_state == DONE);
    assign a_gt_b    = out_valid & w_flags.gt;
    assign a_lt_b    = out_valid & w_flags.lt;
    assign a_eq_b    = out_valid & w_flags.eq;

    // Tie off the unused decode path for lint; lt is implied by !gt on a difference.
    logic w_unused;
    assign w_unused = w_lt;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb/tb_serial_mag_comparator.sv - scoreboard bench for serial_mag_comparator
module tb_serial_mag_comparator;

    localparam logic [2:0] F_GT = 3'b100;
    localparam logic [2:0] F_LT = 3'b010;
    localparam logic [2:0] F_EQ = 3'b001;

    typedef struct {
        logic [2:0] fl;
        int         acc;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic       iv0, ir0, ov0, or0, gt0, lt0, eq0, busy0;
    logic [7:0] a0, b0;
    logic       iv1, ir1, ov1, or1, gt1, lt1, eq1, busy1;
    logic [7:0] a1, b1;

    exp_t q0[$];
    exp_t q1[$];
    logic       prev_ov[2];
    logic [2:0] prev_fl[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_a(a0), .in_b(b0),
        .out_valid(ov0), .out_ready(or0), .a_gt_b(gt0), .a_lt_b(lt0), .a_eq_b(eq0), .busy(busy0)
    );

    serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_ne (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_a(a1), .in_b(b1),
        .out_valid(ov1), .out_ready(or1), .a_gt_b(gt1), .a_lt_b(lt1), .a_eq_b(eq1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic mon(input int w, input logic ov, input logic ordy, input logic [2:0] fl);
        exp_t e;
        int   sz;
        if (ov && !prev_ov[w]) begin
            sz = (w == 0) ? q0.size() : q1.size();
            chk($sformatf("d%0d_expected_pending", w), 32'(sz != 0), 32'd1);
            if (sz != 0) begin
                if (w == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("d%0d_flags", w), 32'(fl), 32'(e.fl));
                chk($sformatf("d%0d_latency", w), 32'(cyc - e.acc), 32'(e.lat));
            end
        end
        if (prev_ov[w] && !ordy) begin
            chk($sformatf("d%0d_hold_valid", w), 32'(ov), 32'd1);
            chk($sformatf("d%0d_hold_flags", w), 32'(fl), 32'(prev_fl[w]));
        end
        if (!ov) chk($sformatf("d%0d_flags_idle", w), 32'(fl), 32'd0);
        prev_ov[w] = ov;
        prev_fl[w] = fl;
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            prev_ov[0] = 1'b0;
            prev_ov[1] = 1'b0;
        end else begin
            mon(0, ov0, or0, {gt0, lt0, eq0});
            mon(1, ov1, or1, {gt1, lt1, eq1});
        end
    end

    task automatic chk_idle(input string tag);
        chk({tag, "_d0_in_ready"}, 32'(ir0), 32'd1);
        chk({tag, "_d0_out_valid"}, 32'(ov0), 32'd0);
        chk({tag, "_d0_busy"}, 32'(busy0), 32'd0);
        chk({tag, "_d0_flags"}, 32'({gt0, lt0, eq0}), 32'd0);
        chk({tag, "_d1_in_ready"}, 32'(ir1), 32'd1);
        chk({tag, "_d1_out_valid"}, 32'(ov1), 32'd0);
        chk({tag, "_d1_busy"}, 32'(busy1), 32'd0);
        chk({tag, "_d1_flags"}, 32'({gt1, lt1, eq1}), 32'd0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int w, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] fl, input int lat, input bit expect_out,
                        output int acc);
        exp_t e;
        int   t;
        logic rdy;
        if (w == 0) begin a0 = a; b0 = b; iv0 = 1'b1; end
        else        begin a1 = a; b1 = b; iv1 = 1'b1; end
        t = 0;
        rdy = (w == 0) ? ir0 : ir1;
        while (!rdy && t < 100) begin
            @(negedge clk);
            t++;
            rdy = (w == 0) ? ir0 : ir1;
        end
        if (!rdy) chk($sformatf("d%0d_accept_timeout", w), 32'(rdy), 32'd1);
        acc = cyc + 1;
        if (expect_out) begin
            e.fl = fl; e.acc = acc; e.lat = lat;
            if (w == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge clk);
        if (w == 0) iv0 = 1'b0;
        else        iv1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int acc, acc1, acc2, hs, t;
        rst_n = 1'b0;
        iv0 = 1'b0; or0 = 1'b1; a0 = '0; b0 = '0;
        iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0;
        prev_ov[0] = 1'b0; prev_ov[1] = 1'b0;
        prev_fl[0] = '0;   prev_fl[1] = '0;

        repeat (3) begin
            @(negedge clk);
            chk_idle("in_reset");
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("after_reset");

        send(0, 8'hA5, 8'h5A, F_GT, 1, 1'b1, acc);
        send(0, 8'h3C, 8'h3C, F_EQ, 8, 1'b1, acc);
        send(0, 8'h10, 8'h11, F_LT, 8, 1'b1, acc);
        send(0, 8'h24, 8'h2C, F_LT, 5, 1'b1, acc);
        send(0, 8'hFF, 8'h00, F_GT, 1, 1'b1, acc);

        send(1, 8'hA5, 8'h5A, F_GT, 8, 1'b1, acc);
        send(1, 8'h3C, 8'h3C, F_EQ, 8, 1'b1, acc);
        send(1, 8'h10, 8'h11, F_LT, 8, 1'b1, acc);

        // Backpressure: new pair waits behind a held result.
        t = 0;
        while (!ir0 && t < 50) begin @(negedge clk); t++; end
        or0 = 1'b0;
        send(0, 8'hA5, 8'h5A, F_GT, 1, 1'b1, acc1);
        hs = 0;
        fork
            send(0, 8'h24, 8'h2C, F_LT, 5, 1'b1, acc2);
            begin
                @(negedge clk);
                repeat (5) begin
                    chk("bp_in_ready", 32'(ir0), 32'd0);
                    chk("bp_out_valid", 32'(ov0), 32'd1);
                    chk("bp_gt", 32'(gt0), 32'd1);
                    @(negedge clk);
                end
                or0 = 1'b1;
                hs = cyc + 1;
            end
        join
        chk("bp_accept_after_hs", 32'(acc2), 32'(hs + 1));

        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin @(negedge clk); t++; end
        chk("drain", 32'(q0.size() + q1.size()), 32'd0);
        t = 0;
        while (!ir0 && t < 50) begin @(negedge clk); t++; end

        // Reset pulse in the third compare cycle discards the operation.
        send(0, 8'h01, 8'h00, F_GT, 8, 1'b0, acc);
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_busy_before", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy0), 32'd0);
        chk("rst_mid_in_ready", 32'(ir0), 32'd1);
        chk("rst_mid_out_valid", 32'(ov0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("rst_mid_no_result", 32'(ov0), 32'd0);
        end
        chk("rst_mid_idle", 32'(ir0), 32'd1);

        send(0, 8'h80, 8'h00, F_GT, 1, 1'b1, acc);
        t = 0;
        while (q0.size() != 0 && t < 50) begin @(negedge clk); t++; end
        chk("final_drain", 32'(q0.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
